crc_nrzi_framer: RTL and testbench
==================================

# crc_nrzi_framer

Parametrised serial frame transmitter. It collects a DATA_W-bit payload one bit at a time and computes a CRC over it while collecting. It then emits payload plus CRC MSB-first, with optional zero-bit stuffing after runs of ones, NRZI-encoded on a single line. It is the next-generation replacement for the fixed 32-bit-data / 16-bit-CRC-A / NRZI datapath, with a start/valid/done handshake added.

## Interface
- DATA_W, 32, payload length in bits (≥1)
- CRC_W, 16, CRC width (8..32)
- CRC_POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
- CRC_INIT, all ones, CRC register value loaded at frame start
- STUFF_EN, 1, 1 = insert a 0 after STUFF_LEN consecutive ones; 0 = no stuffing
- STUFF_LEN, 6, run length that triggers stuffing (≥2)

- CLK  in  1  clock, all logic on rising edge
- resetn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  frame start request; accepted only in IDLE
- data_i  in  1  payload bit, MSB first
- data_valid_i  in  1  data_i qualifier; sampled only in COLLECT
- busy_o  out  1  high in COLLECT, SEND and DONE
- tx_o  out  1  NRZI line level
- tx_valid_o  out  1  high for every transmitted bit period, including stuffed bits
- done_o  out  1  one-cycle pulse at frame end
- crc_o  out  CRC_W  CRC of the last collected payload

## Operation
- FSM states are IDLE, COLLECT, SEND and DONE.
  - IDLE→COLLECT on start_i.
  - COLLECT→SEND on the cycle the DATA_W-th valid bit is accepted.
  - SEND→DONE after the last bit, including any trailing stuff bit.
  - DONE→IDLE unconditionally.
- On an accepted start_i: the CRC register loads CRC_INIT, the bit counter and run counter clear, and the payload shift register clears.
- COLLECT, per accepted bit b:
  - payload shifts left, b enters at the LSB;
  - fb = crc[CRC_W-1]^b;
  - crc = {crc[CRC_W-2:0],0} ^ (fb ? CRC_POLY : 0).
  - No reflection and no final XOR.
- crc_o updates when the last payload bit is accepted. It then holds until the next accepted start_i.
- SEND loads a DATA_W+CRC_W shift register = {payload, crc}.
- Each SEND cycle selects exactly one bit s:
  - if STUFF_EN and run count == STUFF_LEN, s = 0 (stuffed) and the shift register holds;
  - otherwise s = shift register MSB, and the register shifts.
- Run counter: +1 when s = 1, cleared when s = 0 (stuffed zeros included). Saturation is never reached because stuffing resets it.
- If the final CRC bit completes a STUFF_LEN run, one trailing stuffed 0 is sent before DONE.
- NRZI encoding: s = 0 toggles tx_o; s = 1 holds tx_o.
- tx_o keeps its last level between frames.
- start_i is ignored outside IDLE. data_valid_i is ignored outside COLLECT. Gaps in data_valid_i stall COLLECT indefinitely.
- Reset at any point: every state element returns to its reset value and any frame in flight is discarded.

## Timing
- Reset values: busy_o=0, tx_o=1, tx_valid_o=0, done_o=0, crc_o=0, FSM=IDLE.
- start_i sampled high in IDLE at edge N: busy_o is high from N+1, and the first data bit can be accepted at edge N+1.
- Last payload bit accepted at edge M: SEND is entered and crc_o is valid after edge M.
- tx_o and tx_valid_o are registered. The bit chosen in SEND cycle k appears on tx_o during cycle k+1.
- tx_valid_o is high for exactly DATA_W+CRC_W+S consecutive cycles, where S = number of stuffed bits, with no gaps.
- done_o is high for the single cycle after the final tx_valid_o cycle. busy_o falls one cycle later. A start_i in that done cycle is ignored.
- Minimum frame period: 1 + DATA_W + (DATA_W+CRC_W+S) + 2 cycles.

## Test plan
- CRC check value: DATA_W=72, payload ASCII "123456789" (72'h313233343536373839), contiguous valid → crc_o=16'h29B1; 88 tx_valid_o cycles if no run of 6 ones occurs, otherwise match the reference model.
- NRZI toggling: DATA_W=32, STUFF_EN=0, payload 32'h00000000 → tx_o starts at 1 and toggles on each of the first 32 tx_valid_o cycles (first bit level 0); exactly 48 tx_valid_o cycles; done_o pulses once.
- Stuffing: payload 32'hFFFFFFFF, STUFF_EN=1 → stuffed zeros after payload ones 6, 12, 18, 24 and 30 (tx_o toggles at those points); total cycles = 53 + stuffs inside the CRC, matching the model.
- Stalled input: valid deasserted for 5 cycles mid-payload → same crc_o and tx_o sequence as the contiguous case; start_i pulsed during SEND is ignored.
- Mid-frame reset: assert resetn_i low during SEND → immediately busy_o=0, tx_o=1, tx_valid_o=0, crc_o=0; the next frame is correct.
- Back-to-back frames: start_i held high → a new frame begins only after DONE→IDLE, and CRC_INIT is reloaded (second frame's crc_o is independent of the first).

Source files
------------

// File: rtl/crc_nrzi_framer_if.sv
// Handshake and line bundle for crc_nrzi_framer.
// The master side feeds the payload; the slave side is the framer.
interface crc_nrzi_framer_if #(
    parameter int unsigned CRC_W = 16
);
    logic             start_i;
    logic             data_i;
    logic             data_valid_i;
    logic             busy_o;
    logic             tx_o;
    logic             tx_valid_o;
    logic             done_o;
    logic [CRC_W-1:0] crc_o;

    modport master (
        output start_i, data_i, data_valid_i,
        input  busy_o, tx_o, tx_valid_o, done_o, crc_o
    );

    modport slave (
        input  start_i, data_i, data_valid_i,
        output busy_o, tx_o, tx_valid_o, done_o, crc_o
    );
endinterface

// File: rtl/crc_nrzi_framer.sv
// Serial frame transmitter: collects a payload bit-serially while running a CRC,
// then sends {payload, crc} MSB-first with optional zero stuffing, NRZI-encoded.
module crc_nrzi_framer #(
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      CRC_W     = 16,
    parameter logic [CRC_W-1:0] CRC_POLY  = CRC_W'(16'h1021),
    parameter logic [CRC_W-1:0] CRC_INIT  = '1,
    parameter bit               STUFF_EN  = 1'b1,
    parameter int unsigned      STUFF_LEN = 6
) (
    input logic              CLK,
    input logic              resetn_i,
    crc_nrzi_framer_if.slave bus
);
    localparam int unsigned FRAME_W = DATA_W + CRC_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned RUN_W   = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SEND, DONE} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0]  payload, payload_n;
    logic [CRC_W-1:0]   crc, crc_n, crc_out;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt, rem_n;   // COLLECT: bits accepted; SEND: bits left
    logic [RUN_W-1:0]   run_cnt, run_n;
    logic               start_acc, bit_acc, last_bit, stuff, s_bit, send_last;
    logic               done_q, tx_q, tx_valid_q;

    always_ff @(posedge CLK or negedge resetn_i) begin
        if (!resetn_i) state <= IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_acc) state_n = COLLECT;
            COLLECT: if (last_bit)  state_n = SEND;
            SEND:    if (send_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        start_acc = (state == IDLE) && bus.start_i && !done_q;
        bit_acc   = (state == COLLECT) && bus.data_valid_i;
        last_bit  = bit_acc && (bit_cnt == CNT_W'(DATA_W - 1));
        payload_n = DATA_W'({payload, bus.data_i});
        crc_n     = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bus.data_i) ? CRC_POLY : '0);
        stuff     = STUFF_EN && (run_cnt == RUN_W'(STUFF_LEN));
        s_bit     = stuff ? 1'b0 : shreg[FRAME_W-1];
        rem_n     = stuff ? bit_cnt : bit_cnt - CNT_W'(1);
        run_n     = !s_bit ? '0 : (run_cnt == '1) ? run_cnt : run_cnt + RUN_W'(1);
        // Frame ends once every bit is out and no trailing stuff bit is owed.
        send_last = (state == SEND) && (rem_n == '0)
                    && !(STUFF_EN && run_n == RUN_W'(STUFF_LEN));
    end

    always_ff @(posedge CLK or negedge resetn_i) begin
        if (!resetn_i) begin
            payload    <= '0;
            crc        <= '0;
            crc_out    <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            tx_q       <= 1'b1;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= (state == DONE);
            tx_valid_q <= (state == SEND);
            if (start_acc) begin
                crc     <= CRC_INIT;
                payload <= '0;
                bit_cnt <= '0;
                run_cnt <= '0;
            end
            if (bit_acc) begin
                payload <= payload_n;
                crc     <= crc_n;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (last_bit) begin
                    crc_out <= crc_n;
                    shreg   <= {payload_n, crc_n};
                    bit_cnt <= CNT_W'(FRAME_W);
                end
            end
            if (state == SEND) begin
                tx_q    <= s_bit ? tx_q : ~tx_q;
                shreg   <= stuff ? shreg : {shreg[FRAME_W-2:0], 1'b0};
                bit_cnt <= rem_n;
                run_cnt <= run_n;
            end
        end
    end

    // done_o trails DONE by a cycle, so busy_o stretches over it and start_i is masked there.
    assign bus.busy_o     = (state != IDLE) || done_q;
    assign bus.done_o     = done_q;
    assign bus.tx_o       = tx_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.crc_o      = crc_out;
endmodule

// File: tb/tb_crc_nrzi_framer.sv
// Scoreboard bench for crc_nrzi_framer: stimulus queues expected line levels,
// frame lengths and CRCs; a negedge monitor pops and compares them.
module tb_crc_nrzi_framer;
    localparam int unsigned DW   = 72;
    localparam int unsigned CW   = 16;
    localparam int unsigned SLEN = 6;
    localparam int unsigned FW   = DW + CW;

    logic CLK = 1'b0;
    logic resetn_i = 1'b0;
    always #5 CLK = ~CLK;

    crc_nrzi_framer_if #(.CRC_W(CW)) bus ();

    crc_nrzi_framer #(
        .DATA_W(DW), .CRC_W(CW), .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF),
        .STUFF_EN(1'b1), .STUFF_LEN(SLEN)
    ) dut (
        .CLK(CLK), .resetn_i(resetn_i), .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic          exp_lvl_q[$];
    int            exp_len_q[$];
    logic [CW-1:0] exp_crc_q[$];
    logic          model_lvl = 1'b1;
    int            mon_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: output with no expected entry queued", name);
    endtask

    function automatic logic [CW-1:0] crc_model(input logic [DW-1:0] p);
        logic [CW-1:0] c;
        c = 16'hFFFF;
        for (int i = DW - 1; i >= 0; i--)
            c = (c[CW-1] ^ p[i]) ? ({c[CW-2:0], 1'b0} ^ 16'h1021) : {c[CW-2:0], 1'b0};
        return c;
    endfunction

    // Queue the line levels for one frame: stuff after SLEN ones, NRZI toggles on 0.
    task automatic expect_frame(input logic [DW-1:0] p, input logic [CW-1:0] crc_exp);
        logic [FW-1:0] f;
        int run;
        int n;
        f = {p, crc_model(p)};
        run = 0;
        n = 0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (run == SLEN) begin
                model_lvl = ~model_lvl;
                exp_lvl_q.push_back(model_lvl);
                n++;
                run = 0;
            end
            if (!f[i]) model_lvl = ~model_lvl;
            exp_lvl_q.push_back(model_lvl);
            n++;
            run = f[i] ? run + 1 : 0;
        end
        if (run == SLEN) begin
            model_lvl = ~model_lvl;
            exp_lvl_q.push_back(model_lvl);
            n++;
        end
        exp_len_q.push_back(n);
        exp_crc_q.push_back(crc_exp);
    endtask

    always @(negedge CLK) begin
        if (!resetn_i) begin
            mon_cnt = 0;
        end else if (bus.tx_valid_o) begin
            if (exp_lvl_q.size() == 0) unexpected("tx_level");
            else check("tx_level", 32'(bus.tx_o), 32'(exp_lvl_q.pop_front()));
            mon_cnt++;
        end else if (mon_cnt != 0) begin
            check("done_after_last_bit", 32'(bus.done_o), 32'd1);
            check("busy_in_done", 32'(bus.busy_o), 32'd1);
            if (exp_len_q.size() == 0) unexpected("frame_len");
            else begin
                check("frame_len", 32'(mon_cnt), 32'(exp_len_q.pop_front()));
                check("crc_o", 32'(bus.crc_o), 32'(exp_crc_q.pop_front()));
            end
            mon_cnt = 0;
        end else if (bus.done_o) begin
            unexpected("done_pulse");
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("busy_after_start", 32'(bus.busy_o), 32'd1);
    endtask

    task automatic feed(input logic [DW-1:0] p, input int stall_at, input int stall_len);
        for (int i = DW - 1; i >= 0; i--) begin
            if (i == stall_at) begin
                bus.data_valid_i = 1'b0;
                bus.data_i = ~p[i];
                repeat (stall_len) tick();
            end
            bus.data_i = p[i];
            bus.data_valid_i = 1'b1;
            tick();
        end
        bus.data_valid_i = 1'b0;
        bus.data_i = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.done_o && k < 400) begin
            tick();
            k++;
        end
        check("done_seen", 32'(bus.done_o), 32'd1);
        tick();
        check("busy_fall_after_done", 32'(bus.busy_o), 32'd0);
    endtask

    logic [DW-1:0] p_chk, p_alt;

    initial begin
        p_chk = 72'h313233343536373839;
        p_alt = 72'hA5C3_0FF0_FFFF_0000_7E;
        bus.start_i = 1'b0;
        bus.data_i = 1'b0;
        bus.data_valid_i = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_tx", 32'(bus.tx_o), 32'd1);
        check("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_crc", 32'(bus.crc_o), 32'd0);
        resetn_i = 1'b1;
        tick();

        expect_frame(p_chk, 16'h29B1);
        start_frame();
        feed(p_chk, -1, 0);
        wait_done();

        expect_frame('0, crc_model('0));
        start_frame();
        feed('0, -1, 0);
        wait_done();

        expect_frame('1, crc_model('1));
        start_frame();
        feed('1, -1, 0);
        wait_done();

        // Stalled input plus a start_i pulse during SEND
        expect_frame(p_chk, 16'h29B1);
        start_frame();
        feed(p_chk, 40, 5);
        repeat (3) tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_done();

        // Reset in the middle of SEND
        expect_frame(p_alt, crc_model(p_alt));
        start_frame();
        feed(p_alt, -1, 0);
        repeat (10) tick();
        resetn_i = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_tx", 32'(bus.tx_o), 32'd1);
        check("midrst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        check("midrst_crc", 32'(bus.crc_o), 32'd0);
        exp_lvl_q.delete();
        exp_len_q.delete();
        exp_crc_q.delete();
        model_lvl = 1'b1;
        repeat (2) tick();
        resetn_i = 1'b1;
        tick();
        expect_frame(p_chk, 16'h29B1);
        start_frame();
        feed(p_chk, -1, 0);
        wait_done();

        // Back-to-back with start_i held high
        expect_frame(p_alt, crc_model(p_alt));
        expect_frame(p_chk, 16'h29B1);
        bus.start_i = 1'b1;
        tick();
        check("b2b_busy_first", 32'(bus.busy_o), 32'd1);
        feed(p_alt, -1, 0);
        wait_done();
        tick();
        check("b2b_busy_second", 32'(bus.busy_o), 32'd1);
        bus.start_i = 1'b0;
        feed(p_chk, -1, 0);
        wait_done();

        repeat (4) tick();
        check("queue_drained", 32'(exp_lvl_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
